multicycle_control: RTL

//  Multi-cycle RV32I control unit; drives the ALU interface: ALUop, funct3, funct7 and operand selects.

---
 rtl/multicycle_control_if.sv | 59 +++++
 rtl/multicycle_control.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
//   Bundles every signal between the multi-cycle RV32I control unit and the
//   rest of the core (instruction memory, data memory, ALU, register file,
//   PC logic).
//
//   Handshakes:
//     imem_req / imem_valid : imem_req is held high while the controller
//       waits for an instruction. The cycle in which imem_valid is high
//       while imem_req is high is the transfer cycle: instr is captured and
//       ir_write pulses.
//     mem_read|mem_write / dmem_ready : the strobe is held high until the
//       cycle in which dmem_ready is high. That cycle completes the access.
//
//   modport master : the control unit
//   modport slave  : the datapath / memories driving the control unit
// ---------------------------------------------------------------------------
interface multicycle_control_if #(
    parameter int RETIRE_W = 32
) ();
    // inputs to the control unit
    logic [31:0]         instr;
    logic                imem_valid;
    logic                dmem_ready;
    logic                branchTaken;
    // outputs of the control unit
    logic                imem_req;
    logic                ir_write;
    logic [3:0]          ALUop;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                alu_src_a;
    logic                alu_src_b;
    logic [31:0]         imm;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                reg_write;
    logic                wb_sel;
    logic                mem_read;
    logic                mem_write;
    logic                pc_write;
    logic [1:0]          pc_src;
    logic [RETIRE_W-1:0] retired;

    modport master (
        input  instr, imem_valid, dmem_ready, branchTaken,
        output imem_req, ir_write, ALUop, funct3, funct7, alu_src_a, alu_src_b,
               imm, rs1, rs2, rd, reg_write, wb_sel, mem_read, mem_write,
               pc_write, pc_src, retired
    );

    modport slave (
        output instr, imem_valid, dmem_ready, branchTaken,
        input  imem_req, ir_write, ALUop, funct3, funct7, alu_src_a, alu_src_b,
               imm, rs1, rs2, rd, reg_write, wb_sel, mem_read, mem_write,
               pc_write, pc_src, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Multi-cycle RV32I control unit. Latches the fetched instruction, decodes
//   it and sequences IDLE/FETCH/DECODE/EXECUTE/MEM/WRITEBACK, producing ALU
//   controls, operand selects, register-file, data-memory and PC strobes and
//   a count of retired instructions (one per PC update).
//
//   Ports:
//     clk, rst_n     : clock (rising edge), asynchronous active-low reset
//     bus (master)   : all instruction/data/ALU/RF/PC signals, see
//                      multicycle_control_if
//     state_o        : current FSM state (debug visibility)
//     illegal_instr  : sticky illegal-opcode flag (only with ILLEGAL_TRAP_EN)
//
//   Configuration macro: ILLEGAL_TRAP_EN
//     defined   : unknown opcodes enter TRAP from DECODE and set the sticky
//                 illegal_instr output; TRAP is left only through reset.
//     undefined : unknown opcodes execute as a NOP (PC+4, retire, no write).
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RETIRE_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus,
    output logic [2:0]           state_o
`ifdef ILLEGAL_TRAP_EN
    ,output logic                illegal_instr
`endif
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [2:0] S_TRAP      = 3'd6;
`endif

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef ILLEGAL_TRAP_EN
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

    logic [2:0]          state_q, state_d;
    logic [31:0]         ir_q, ir_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    // ---------------- instruction decode (from the latched IR) -------------
    logic [6:0]  opcode;
    logic        is_r, is_i, is_load, is_store, is_branch;
    logic        is_jal, is_jalr, is_lui, is_auipc;
    logic        writes_rd;
    logic [3:0]  dec_aluop;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic        dec_src_a, dec_src_b;
    logic [31:0] dec_imm;
    logic        dec_valid;

    assign opcode    = ir_q[6:0];
    assign is_r      = (opcode == OP_R);
    assign is_i      = (opcode == OP_I);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_lui    = (opcode == OP_LUI);
    assign is_auipc  = (opcode == OP_AUIPC);

    // FENCE, SYSTEM and unknown opcodes fall through as NOPs: no RF write.
    assign writes_rd = is_r | is_i | is_load | is_jal | is_jalr | is_lui | is_auipc;

`ifdef ILLEGAL_TRAP_EN
    logic known_op;
    logic illegal_q, illegal_d;
    assign known_op = is_r | is_i | is_load | is_store | is_branch | is_jal |
                      is_jalr | is_lui | is_auipc |
                      (opcode == OP_FENCE) | (opcode == OP_SYSTEM);
`endif

    always_comb begin
        dec_aluop  = 4'b0000;
        dec_funct3 = 3'b000;
        dec_funct7 = 7'b0000000;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        dec_imm    = 32'd0;
        if (is_r) begin
            dec_aluop  = 4'b0000;
            dec_funct3 = ir_q[14:12];
            dec_funct7 = ir_q[31:25];
        end else if (is_i) begin
            dec_aluop  = 4'b0001;
            dec_funct3 = ir_q[14:12];
            dec_funct7 = ir_q[31:25];
            dec_src_b  = 1'b1;
            dec_imm    = {{20{ir_q[31]}}, ir_q[31:20]};
        end else if (is_load) begin
            dec_aluop  = 4'b0010;
            dec_funct3 = ir_q[14:12];
            dec_src_b  = 1'b1;
            dec_imm    = {{20{ir_q[31]}}, ir_q[31:20]};
        end else if (is_store) begin
            dec_aluop  = 4'b0010;
            dec_funct3 = ir_q[14:12];
            dec_src_b  = 1'b1;
            dec_imm    = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        end else if (is_branch) begin
            dec_aluop  = 4'b0011;
            dec_funct3 = ir_q[14:12];
            dec_imm    = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                          ir_q[11:8], 1'b0};
        end else if (is_jal) begin
            dec_aluop  = 4'b0100;
            dec_src_a  = 1'b1;
            dec_src_b  = 1'b1;
            dec_imm    = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20],
                          ir_q[30:21], 1'b0};
        end else if (is_jalr) begin
            dec_aluop  = 4'b0100;
            dec_src_a  = 1'b1;
            dec_src_b  = 1'b1;
            dec_imm    = {{20{ir_q[31]}}, ir_q[31:20]};
        end else if (is_lui) begin
            // LUI carries the raw 20-bit field; the ALU does the shift.
            dec_aluop  = 4'b0101;
            dec_src_b  = 1'b1;
            dec_imm    = {12'd0, ir_q[31:12]};
        end else if (is_auipc) begin
            dec_aluop  = 4'b0010;
            dec_src_a  = 1'b1;
            dec_src_b  = 1'b1;
            dec_imm    = {ir_q[31:12], 12'd0};
        end
    end

    // Decode outputs are only meaningful once an instruction has been latched
    // for this pass; outside DECODE..WRITEBACK they are held at zero.
    assign dec_valid = (state_q == S_DECODE) || (state_q == S_EXECUTE) ||
                       (state_q == S_MEM)    || (state_q == S_WRITEBACK);

    assign bus.ALUop     = dec_valid ? dec_aluop  : 4'b0000;
    assign bus.funct3    = dec_valid ? dec_funct3 : 3'b000;
    assign bus.funct7    = dec_valid ? dec_funct7 : 7'b0000000;
    assign bus.alu_src_a = dec_valid & dec_src_a;
    assign bus.alu_src_b = dec_valid & dec_src_b;
    assign bus.imm       = dec_valid ? dec_imm    : 32'd0;
    assign bus.rs1       = dec_valid ? ir_q[19:15] : 5'd0;
    assign bus.rs2       = dec_valid ? ir_q[24:20] : 5'd0;
    assign bus.rd        = dec_valid ? ir_q[11:7]  : 5'd0;

    // ---------------- strobes --------------------------------------------
    logic pc_write;
    logic mem_done;

    assign mem_done      = (state_q == S_MEM) && bus.dmem_ready;
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.ir_write  = (state_q == S_FETCH) && bus.imem_valid;
    assign bus.mem_read  = (state_q == S_MEM) && is_load;
    assign bus.mem_write = (state_q == S_MEM) && is_store;
    assign bus.reg_write = (state_q == S_WRITEBACK) && writes_rd && (ir_q[11:7] != 5'd0);
    assign bus.wb_sel    = (state_q == S_WRITEBACK) && is_load;

    // Branches retire in EXECUTE, stores on the completing MEM cycle and
    // everything else in WRITEBACK.
    assign pc_write = ((state_q == S_EXECUTE) && is_branch) ||
                      (mem_done && is_store) ||
                      (state_q == S_WRITEBACK);
    assign bus.pc_write = pc_write;

    always_comb begin
        bus.pc_src = 2'b00;
        if ((state_q == S_EXECUTE) && is_branch) begin
            bus.pc_src = bus.branchTaken ? 2'b01 : 2'b00;
        end else if (state_q == S_WRITEBACK) begin
            if (is_jal) begin
                bus.pc_src = 2'b01;
            end else if (is_jalr) begin
                bus.pc_src = 2'b10;
            end
        end
    end

    assign bus.retired = retired_q;
    assign state_o     = state_q;

    // ---------------- next state -------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     if (bus.imem_valid) state_d = S_DECODE;
`ifdef ILLEGAL_TRAP_EN
            S_DECODE:    state_d = known_op ? S_EXECUTE : S_TRAP;
            S_TRAP:      state_d = S_TRAP;
`else
            S_DECODE:    state_d = S_EXECUTE;
`endif
            S_EXECUTE: begin
                if (is_branch) begin
                    state_d = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEM:       if (bus.dmem_ready) state_d = is_store ? S_FETCH : S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            default:     state_d = S_IDLE;
        endcase
    end

    assign ir_d      = bus.ir_write ? bus.instr : ir_q;
    assign retired_d = pc_write ? retired_q + 1'b1 : retired_q;

`ifdef ILLEGAL_TRAP_EN
    assign illegal_d     = illegal_q | ((state_q == S_DECODE) && !known_op);
    assign illegal_instr = illegal_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'd0;
            retired_q <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

endmodule
